// File: rtl/move_collector_if.sv
// rtl/move_collector_if.sv - move word output stream between collector and consumer
interface move_collector_if;
  logic [31:0] move_out;
  logic        move_valid;
  logic        move_ready;

  modport master (output move_out, output move_valid, input move_ready);
  modport slave  (input move_out, input move_valid, output move_ready);
endinterface

// File: rtl/move_collector.sv
// rtl/move_collector.sv - snapshot scan of per-square move words into an output FIFO
// Optional MOVE_COLLECTOR_CAPTURE_FIRST_EN: two passes, capture moves ([29:24] != 0) first.
module move_collector #(
  parameter int NUM_SQUARES = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                                   clk,
  input  logic                                   clear,
  input  logic                                   enable,
  input  logic                                   start,
  input  logic [NUM_SQUARES*512-1:0]             moves_in,
  output logic                                   busy,
  output logic                                   done,
  output logic [$clog2(NUM_SQUARES*16+1)-1:0]    move_count,
  move_collector_if.master                       mv
);
  localparam int NW = NUM_SQUARES * 16;
  localparam int CW = $clog2(NW + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [NUM_SQUARES*512-1:0] snap_q;
  logic [CW-1:0]              idx_q, idx_d;
  logic [CW-1:0]              count_q, count_d;
  logic [31:0]                mem [FIFO_DEPTH];
  logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]              occ_q;
  logic [31:0]                word;
  logic                       want, full, push, pop, snap_load, last;
`ifdef MOVE_COLLECTOR_CAPTURE_FIRST_EN
  logic                       pass_q, pass_d;
`endif

  assign word = snap_q[idx_q*32 +: 32];
  assign last = (idx_q == CW'(NW - 1));
  assign full = (occ_q == OW'(FIFO_DEPTH));
  assign pop  = (occ_q != '0) && mv.move_ready;

`ifdef MOVE_COLLECTOR_CAPTURE_FIRST_EN
  // Pass 0 takes captures only, pass 1 the quiet moves.
  assign want = (word != 32'h0) && ((word[29:24] != 6'h0) ^ pass_q);
`else
  assign want = (word != 32'h0);
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    push      = 1'b0;
    snap_load = 1'b0;
`ifdef MOVE_COLLECTOR_CAPTURE_FIRST_EN
    pass_d    = pass_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && enable) begin
          state_d   = S_SCAN;
          idx_d     = '0;
          count_d   = '0;
          snap_load = 1'b1;
`ifdef MOVE_COLLECTOR_CAPTURE_FIRST_EN
          pass_d    = 1'b0;
`endif
        end
      end
      S_SCAN: begin
        // A wanted word with the FIFO full holds the index until space frees.
        if (enable && !(want && full)) begin
          push = want;
          if (want) count_d = count_q + CW'(1);
          if (!last) begin
            idx_d = idx_q + CW'(1);
          end else begin
`ifdef MOVE_COLLECTOR_CAPTURE_FIRST_EN
            if (!pass_q) begin
              pass_d = 1'b1;
              idx_d  = '0;
            end else begin
              state_d = S_DONE;
            end
`else
            state_d = S_DONE;
`endif
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
`ifdef MOVE_COLLECTOR_CAPTURE_FIRST_EN
      pass_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_q + PW'(push);
      rd_ptr_q <= rd_ptr_q + PW'(pop);
      occ_q    <= occ_q + OW'(push) - OW'(pop);
`ifdef MOVE_COLLECTOR_CAPTURE_FIRST_EN
      pass_q   <= pass_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (snap_load && !clear) snap_q <= moves_in;
    if (push) mem[wr_ptr_q] <= word;
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign move_count    = count_q;
  assign mv.move_valid = (occ_q != '0);
  assign mv.move_out   = (occ_q != '0) ? mem[rd_ptr_q] : 32'h0;
endmodule

// File: tb/tb_move_collector.sv
// tb/tb_move_collector.sv - directed scoreboard bench for move_collector
module tb_move_collector;
`ifdef MOVE_COLLECTOR_CAPTURE_FIRST_EN
  localparam int SCAN = 64;
`else
  localparam int SCAN = 32;
`endif

  logic          clk = 1'b0;
  logic          clear, enable, start_a, start_b;
  logic [1023:0] moves_in;
  logic          busy_a, done_a, busy_b, done_b;
  logic [5:0]    cnt_a, cnt_b;
  logic          done_a_s, done_b_s;
  logic [31:0]   exp_a[$];
  logic [31:0]   exp_b[$];
  int            tests = 0;
  int            fails = 0;
  int            c;

  move_collector_if mv_a ();
  move_collector_if mv_b ();

  move_collector #(.NUM_SQUARES(2), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .clear(clear), .enable(enable), .start(start_a), .moves_in(moves_in),
    .busy(busy_a), .done(done_a), .move_count(cnt_a), .mv(mv_a.master));

  move_collector #(.NUM_SQUARES(2), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .clear(clear), .enable(enable), .start(start_b), .moves_in(moves_in),
    .busy(busy_b), .done(done_b), .move_count(cnt_b), .mv(mv_b.master));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    done_a_s = done_a;
    done_b_s = done_b;
    if (mv_a.move_valid === 1'b1 && mv_a.move_ready === 1'b1) begin
      chk("a_sb_nonempty", 64'(exp_a.size() != 0), 1);
      if (exp_a.size() != 0) chk("a_order", mv_a.move_out, exp_a.pop_front());
    end
    if (mv_b.move_valid === 1'b1 && mv_b.move_ready === 1'b1) begin
      chk("b_sb_nonempty", 64'(exp_b.size() != 0), 1);
      if (exp_b.size() != 0) chk("b_order", mv_b.move_out, exp_b.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_done(input bit sel_b, input int c0, output int cyc);
    cyc = c0;
    tick();
    while (!((sel_b ? done_b_s : done_a_s) === 1'b1) && cyc < c0 + 400) begin
      cyc++;
      tick();
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] w);
    moves_in[idx*32 +: 32] = w;
  endtask

  initial begin
    clear = 1'b1; enable = 1'b1; start_a = 1'b0; start_b = 1'b0; moves_in = '0;
    mv_a.move_ready = 1'b1; mv_b.move_ready = 1'b1;
    done_a_s = 1'b0; done_b_s = 1'b0;
    ticks(2);
    clear = 1'b0;
    tick();
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_valid", mv_a.move_valid, 0);
    chk("rst_out", mv_a.move_out, 0);
    chk("rst_count", cnt_a, 0);

    // single pass
    set_word(1, 32'h0014_0013); set_word(21, 32'h0017_181F);
    exp_a.push_back(32'h0014_0013); exp_a.push_back(32'h0017_181F);
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_done(0, 1, c);
    chk("t1_done_cycle", c, SCAN + 1);
    chk("t1_count", cnt_a, 2);
    ticks(2);
    chk("t1_drained", exp_a.size(), 0);
    chk("t1_idle", busy_a, 0);

    // enable gating
    exp_a.push_back(32'h0014_0013); exp_a.push_back(32'h0017_181F);
    start_a = 1'b1; tick(); start_a = 1'b0;
    ticks(9);
`ifdef MOVE_COLLECTOR_CAPTURE_FIRST_EN
    chk("t3_count_pre", cnt_a, 0);
`else
    chk("t3_count_pre", cnt_a, 1);
`endif
    enable = 1'b0;
    ticks(4);
`ifdef MOVE_COLLECTOR_CAPTURE_FIRST_EN
    chk("t3_count_frozen", cnt_a, 0);
`else
    chk("t3_count_frozen", cnt_a, 1);
`endif
    chk("t3_busy_frozen", busy_a, 1);
    enable = 1'b1;
    wait_done(0, 14, c);
    chk("t3_done_cycle", c, SCAN + 5);
    chk("t3_count", cnt_a, 2);
    ticks(2);

    // clear mid-scan with three words queued
    moves_in = '0;
    set_word(0, 32'h0100_0001); set_word(1, 32'h0100_0002); set_word(2, 32'h0100_0003);
    mv_a.move_ready = 1'b0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    ticks(9);
    chk("t4_count_pre", cnt_a, 3);
    chk("t4_head_pre", mv_a.move_out, 32'h0100_0001);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("t4_busy", busy_a, 0);
    chk("t4_valid", mv_a.move_valid, 0);
    chk("t4_out", mv_a.move_out, 0);
    chk("t4_count", cnt_a, 0);
    mv_a.move_ready = 1'b1;
    exp_a.push_back(32'h0100_0001); exp_a.push_back(32'h0100_0002); exp_a.push_back(32'h0100_0003);
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_done(0, 1, c);
    chk("t4_rescan_done", c, SCAN + 1);
    chk("t4_rescan_count", cnt_a, 3);
    ticks(2);
    chk("t4_drained", exp_a.size(), 0);

    // clear wins over start
    clear = 1'b1; start_a = 1'b1; tick(); clear = 1'b0; start_a = 1'b0;
    chk("t5_clear_prio", busy_a, 0);

    // backpressure on the two-deep instance
    moves_in = '0;
    set_word(3, 32'h0000_1003); set_word(7, 32'h0000_1007); set_word(12, 32'h0000_100C);
    set_word(20, 32'h0000_1014); set_word(30, 32'h0000_101E);
    exp_b.push_back(32'h0000_1003); exp_b.push_back(32'h0000_1007); exp_b.push_back(32'h0000_100C);
    exp_b.push_back(32'h0000_1014); exp_b.push_back(32'h0000_101E);
    mv_b.move_ready = 1'b0;
    start_b = 1'b1; tick(); start_b = 1'b0;
    ticks(60);
    chk("t6_busy_stall", busy_b, 1);
    chk("t6_count_stall", cnt_b, 2);
    chk("t6_head", mv_b.move_out, exp_b[0]);
    chk("t6_no_done", done_b_s, 0);
    mv_b.move_ready = 1'b1;
    wait_done(1, 62, c);
    chk("t6_done_seen", done_b_s, 1);
    chk("t6_count", cnt_b, 5);
    ticks(3);
    chk("t6_drained", exp_b.size(), 0);

    // start while busy is ignored
    moves_in = '0;
    set_word(1, 32'h0014_0013); set_word(21, 32'h0017_181F);
    exp_a.push_back(32'h0014_0013); exp_a.push_back(32'h0017_181F);
    start_a = 1'b1; tick(); start_a = 1'b0;
    ticks(5);
    moves_in = '0;
    set_word(1, 32'hFFFF_FFFF); set_word(5, 32'h0000_1234);
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_done(0, 7, c);
    chk("t7_done_cycle", c, SCAN + 1);
    chk("t7_count", cnt_a, 2);
    ticks(2);
    chk("t7_drained", exp_a.size(), 0);

    // capture-first ordering (single pass keeps index order)
    moves_in = '0;
    set_word(0, 32'h0000_1814); set_word(5, 32'h0A00_1814);
`ifdef MOVE_COLLECTOR_CAPTURE_FIRST_EN
    exp_a.push_back(32'h0A00_1814); exp_a.push_back(32'h0000_1814);
`else
    exp_a.push_back(32'h0000_1814); exp_a.push_back(32'h0A00_1814);
`endif
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_done(0, 1, c);
    chk("t8_done_cycle", c, SCAN + 1);
    chk("t8_count", cnt_a, 2);
    ticks(2);
    chk("t8_drained", exp_a.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/move_collector.md
MOVE_COLLECTOR -- requirements
Module: move_collector

Interface
REQ-001 SHALL have parameter NUM_SQUARES, default 2, giving the number of squares whose move words are collected (1..64).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, giving the output FIFO entries (power of two, 2..64).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port clear, input, 1, synchronous active-high reset.
REQ-005 SHALL have port enable, input, 1; high lets the scan advance.
REQ-006 SHALL have port start, input, 1; single-cycle request to snapshot and scan moves_in.
REQ-007 SHALL have port moves_in, input, NUM_SQUARES*512, with 16 move words of 32 bits per square.
  Word index i = square*16 + dir, located at bits [32*i+31:32*i].
  dir order 0..15: U,D,L,R,UL,UR,DL,DR,UUL,UUR,LLU,RRU,DDL,DDR,LLD,RRD.
REQ-008 SHALL have port busy, output, 1; high while the FSM is not IDLE.
REQ-009 SHALL have port done, output, 1; one-cycle pulse at scan completion.
REQ-010 SHALL have port move_out, output, 32; FIFO head word.
REQ-011 SHALL have port move_valid, output, 1; high when the FIFO is non-empty.
REQ-012 SHALL have port move_ready, input, 1; consumer accepts move_out when it is high together with move_valid.
REQ-013 SHALL have port move_count, output, $clog2(NUM_SQUARES*16+1); number of words pushed by the current or last scan.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN, DONE.
  IDLE->SCAN: on start=1 with enable=1.
  SCAN->DONE: after the last index is resolved.
  DONE->IDLE: always, after one cycle.
REQ-015 SHALL, on the start edge, register moves_in into a snapshot, clear move_count and set the index to 0; later moves_in changes SHALL NOT affect the scan.
REQ-016 SHALL ignore start while busy=1.
REQ-017 SHALL resolve one index per SCAN cycle when enable=1:
  - word == 32'h0: skip, index+1.
  - word != 0 and FIFO not full: push, move_count+1, index+1.
  - word != 0 and FIFO full: hold index (stall), no push.
REQ-018 SHALL freeze the index, state and move_count while enable=0. FIFO pops SHALL continue.
REQ-019 SHALL produce done=1 exactly in the DONE cycle. With no stalls and no second pass, a start sampled on edge k SHALL give done high in cycle k+1+NUM_SQUARES*16.
REQ-020 SHALL pop the FIFO when move_valid=1 and move_ready=1. move_out SHALL present the next entry on the following cycle.
REQ-021 SHALL leave occupancy unchanged on a simultaneous push and pop.
  Push SHALL be decided on registered occupancy only; there is no full-bypass.
REQ-022 SHALL ignore move_ready while the FIFO is empty. move_out SHALL be 32'h0 when empty.
REQ-023 SHALL wrap FIFO pointers modulo FIFO_DEPTH. Occupancy SHALL be tracked to FIFO_DEPTH inclusive.
REQ-024 SHALL retain FIFO contents across scans; a new scan appends behind undrained words.

Reset
REQ-025 SHALL, with clear=1 at an edge from any state (including mid-scan), produce:
  - state IDLE, index 0, move_count 0;
  - FIFO emptied; busy=0, done=0, move_valid=0, move_out=32'h0.
REQ-026 SHALL give clear priority over start, enable and move_ready in the same cycle.

Configuration
REQ-027 SHALL, when macro MOVE_COLLECTOR_CAPTURE_FIRST_EN is defined, scan in two passes over all indices:
  - pass 1 pushes only non-zero words with captured piece [29:24] != 0;
  - pass 2 pushes only non-zero words with [29:24] == 0;
  - each pass takes NUM_SQUARES*16 cycles plus stalls;
  - done is raised after pass 2.
REQ-028 SHALL, without the macro, perform a single pass in index order and push every non-zero word.

Verification
REQ-029 SHALL test a single-pass scan:
  - Stimulus: NUM_SQUARES=2; words idx1=32'h0014_0013, idx21=32'h0017_181F, rest 0; start at edge 0; move_ready=1.
  - Response: done high in cycle 33; move_count=2; FIFO order idx1 then idx21.
REQ-030 SHALL test backpressure:
  - Stimulus: FIFO_DEPTH=2; 5 non-zero words; move_ready=0.
  - Response: the scan stalls holding index at the 3rd word with busy=1; raising move_ready drains all 5 words in order; done follows the last push.
REQ-031 SHALL test enable gating:
  - Stimulus: enable=0 for 4 cycles mid-scan.
  - Response: index and move_count frozen; done delayed by exactly 4 cycles.
REQ-032 SHALL test clear mid-scan:
  - Stimulus: clear at scan cycle 10 with 3 words queued.
  - Response: next cycle busy=0, move_valid=0, move_count=0; a following start rescans from index 0.
REQ-033 SHALL test capture-first ordering:
  - Stimulus: MOVE_COLLECTOR_CAPTURE_FIRST_EN defined; idx0=32'h0000_1814, idx5=32'h0A00_1814.
  - Response: output order idx5 then idx0; done in cycle 65.
REQ-034 SHALL test start while busy:
  - Stimulus: start pulsed during SCAN.
  - Response: ignored; snapshot and move_count unchanged.
